a_skew_feeder: RTL and testbench
================================

Name: a_skew_feeder

Overview:
- Upstream feeder for the systolic array A inputs. Holds one DIM x DIM A-matrix tile, loaded one 64-bit row per write from the host bus.
- On start, streams the tile into the array one diagonal per beat: lane i is delayed by i cycles, producing the wavefront skew the array rows expect.
- Sits between the host write path and the systolic array. Array stalls apply backpressure through stall.

Parameters:
BITS_AB, 8, width of one A element
DIM, 8, array dimension; tile is DIM x DIM, stream lasts 2*DIM-1 beats

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load  input  1  write row_in into tile row load_row
load_row  input  $clog2(DIM)  destination row index
row_in  input  BITS_AB*DIM  row data; element c = row_in[c*BITS_AB +: BITS_AB] = A[row][c]
start  input  1  begin streaming the stored tile
stall  input  1  freeze stream (array enable low)
a_out  output  BITS_AB*DIM  lane i = a_out[i*BITS_AB +: BITS_AB], drives array row i
a_valid  output  1  a_out holds a new beat this cycle
busy  output  1  high in STREAM and DONE
done  output  1  one-cycle pulse after the final beat
load_err  output  1  sticky: load attempted while busy

Behaviour:
Reset (async, rst_n low):
- State = IDLE; all tile entries = 0; beat counter t = 0.
- a_out = 0, a_valid = 0, busy = 0, done = 0, load_err = 0.
- Takes effect immediately, including mid-stream. No partial beats after reset release.

States:
- IDLE -> STREAM on start (when load is low).
- STREAM -> DONE on the edge that emits beat t = 2*DIM-2.
- DONE -> IDLE unconditionally after 1 cycle.

Load:
- In IDLE with load=1, tile[load_row] <= row_in at the edge.
- Load has priority over start: if both are asserted in IDLE, the row is written and start is ignored (no stream, no error).
- Load while busy: tile unchanged, load_err <= 1.
- load_err is cleared only by reset or by an accepted start.

Stream:
- Beat count t runs 0 .. 2*DIM-2. Counter width is $clog2(2*DIM).
- At each edge in STREAM with stall=0:
  - lane i of a_out <= tile[i][t-i] if 0 <= t-i <= DIM-1, else 0.
  - a_valid <= 1; t <= t+1.
- With stall=1: a_out holds, a_valid <= 0, t holds. There is no limit on stall length.

Timing:
- Registered outputs. start sampled at edge k gives beat 0 visible after edge k+1, at the earliest.
- Stall sampled at an edge suppresses that edge's beat. Unstalled, beats occupy 2*DIM-1 consecutive cycles.
- done = 1 in the DONE cycle, which immediately follows the last valid beat. In DONE: a_valid = 0, a_out = 0, t reset to 0.

Ignored inputs:
- start while busy is ignored.
- stall outside STREAM has no effect.
- The tile is retained after DONE, so start can be repeated to re-stream without reloading.

Data handling:
- No arithmetic. Elements are passed unchanged and unsigned/signed-agnostic.
- Zero lanes are exact zeros.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, start -> 15 beats of all-zero a_out with a_valid=1, then done pulse (DIM=8).
2. Load tile A[r][c] = 8r+c+1 (rows 0..7), start, no stall -> a_valid high 15 consecutive cycles, exact beat contents:
   - beat 0: lane0 = 1, lanes 1-7 = 0.
   - beat 7: lane i = 8i+(7-i)+1, i.e. lane0 = 8, lane7 = 57.
   - beat 14: lane7 = 64, others 0.
   - done = 1 the next cycle, busy falls the cycle after.
3. Same tile with stall high for 3 cycles after beat 4 -> a_valid low 3 cycles with a_out holding beat 4; beat 5 follows unchanged; total stream 18 cycles, contents identical to scenario 2.
4. Load row 2 = all 0xFF during STREAM -> load_err = 1, output unaffected. Restart -> tile row 2 still original, load_err clears on the accepted start.
5. load and start in the same IDLE cycle -> row written, busy stays 0, no a_valid. Next start -> stream reflects the new row.
6. rst_n low at beat 9 -> a_out/a_valid/busy = 0 immediately. After release, start streams zeros (tile cleared); no done from the aborted stream.

Source files
------------

// File: rtl/a_skew_feeder_if.sv
// Host/array-side bundle for the A-operand skew feeder.
// The master side is the host write path plus the array stall line; the
// slave side is the feeder itself, which drives the skewed lanes and status.
interface a_skew_feeder_if #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
);
   localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

   logic                   load;
   logic [RW-1:0]          load_row;
   logic [BITS_AB*DIM-1:0] row_in;
   logic                   start;
   logic                   stall;
   logic [BITS_AB*DIM-1:0] a_out;
   logic                   a_valid;
   logic                   busy;
   logic                   done;
   logic                   load_err;

   modport master (
      output load, load_row, row_in, start, stall,
      input  a_out, a_valid, busy, done, load_err
   );

   modport slave (
      input  load, load_row, row_in, start, stall,
      output a_out, a_valid, busy, done, load_err
   );
endinterface

// File: rtl/a_skew_feeder.sv
// A-operand skew feeder for the systolic array.
// Holds one DIM x DIM tile written row by row, then on start emits one
// anti-diagonal per beat so lane i sees row i delayed by i cycles.
// All outputs are registered; the array can freeze the stream with stall.
module a_skew_feeder #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   a_skew_feeder_if.slave   bus
);
   localparam int W  = BITS_AB * DIM;
   localparam int CW = $clog2(2 * DIM);
   localparam logic [CW-1:0] LAST_BEAT = CW'(2 * DIM - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   t_q;
   logic [W-1:0]    tile_q [DIM];
   logic [W-1:0]    a_out_q;
   logic            a_valid_q;
   logic            busy_q;
   logic            done_q;
   logic            load_err_q;
   logic [W-1:0]    beat_d;

   // Beat t: lane i carries tile[i][t-i] where that column exists, else zero.
   always_comb begin
      beat_d = '0;
      for (int i = 0; i < DIM; i++) begin
         for (int c = 0; c < DIM; c++) begin
            beat_d[i*BITS_AB +: BITS_AB] = beat_d[i*BITS_AB +: BITS_AB]
               | ((t_q == CW'(i + c)) ? tile_q[i][c*BITS_AB +: BITS_AB]
                                       : {BITS_AB{1'b0}});
         end
      end
   end

   // Control FSM with tile storage and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         t_q        <= '0;
         a_out_q    <= '0;
         a_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
         for (int r = 0; r < DIM; r++) begin
            tile_q[r] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               a_valid_q <= 1'b0;
               done_q    <= 1'b0;
               a_out_q   <= '0;
               t_q       <= '0;
               // A write wins over start in the same cycle.
               if (bus.load) begin
                  tile_q[bus.load_row] <= bus.row_in;
                  busy_q               <= 1'b0;
               end else if (bus.start) begin
                  state_q    <= ST_STREAM;
                  busy_q     <= 1'b1;
                  load_err_q <= 1'b0;
               end else begin
                  busy_q <= 1'b0;
               end
            end

            ST_STREAM: begin
               busy_q <= 1'b1;
               done_q <= 1'b0;
               if (bus.load) begin
                  load_err_q <= 1'b1;
               end
               if (bus.stall) begin
                  // Hold lanes, suppress this beat, keep the beat index.
                  a_valid_q <= 1'b0;
               end else begin
                  a_out_q   <= beat_d;
                  a_valid_q <= 1'b1;
                  t_q       <= t_q + CW'(1);
                  if (t_q == LAST_BEAT) begin
                     state_q <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               // Completion cycle: lanes cleared, done pulses, busy still high.
               a_out_q   <= '0;
               a_valid_q <= 1'b0;
               done_q    <= 1'b1;
               busy_q    <= 1'b1;
               t_q       <= '0;
               state_q   <= ST_IDLE;
               if (bus.load) begin
                  load_err_q <= 1'b1;
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               t_q       <= '0;
               a_out_q   <= '0;
               a_valid_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_out    = a_out_q;
   assign bus.a_valid  = a_valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_a_skew_feeder.sv
// Directed bench for a_skew_feeder (DIM=8, BITS_AB=8).
// Expected beats come from a bench-side tile model and are queued when a
// stream is started, then popped as the feeder presents valid beats.
module tb_a_skew_feeder;
   localparam int B  = 8;
   localparam int D  = 8;
   localparam int W  = B * D;
   localparam int NB = 2 * D - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   a_skew_feeder_if #(.BITS_AB(B), .DIM(D)) bus ();

   a_skew_feeder #(.BITS_AB(B), .DIM(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [B-1:0] mt [D][D];
   logic [W-1:0] sb [$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [W-1:0] exp_beat(input int t);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < D; i++) begin
         if ((t - i) >= 0 && (t - i) < D) v[i*B +: B] = mt[i][t-i];
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // {a_valid, busy, done, load_err}
   function automatic logic [W-1:0] flags();
      return W'({bus.a_valid, bus.busy, bus.done, bus.load_err});
   endfunction

   task automatic clear_model();
      for (int r = 0; r < D; r++)
         for (int c = 0; c < D; c++) mt[r][c] = 8'd0;
   endtask

   task automatic do_load(input int r, input logic [W-1:0] data);
      bus.load     = 1'b1;
      bus.load_row = 3'(r);
      bus.row_in   = data;
      @(negedge clk);
      bus.load = 1'b0;
      for (int c = 0; c < D; c++) mt[r][c] = data[c*B +: B];
   endtask

   // Starts a stream from a negedge and checks it to completion (or abort).
   task automatic run_stream(input int stall_after, input int stall_len,
                             input bit load_mid, input int abort_at,
                             input logic exp_err);
      int beats, first, last, stalls;
      bit got_done, did_load, aborted;
      logic [W-1:0] last_out;
      for (int t = 0; t < NB; t++) sb.push_back(exp_beat(t));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_flags", flags(), W'(4'b0100));
      beats = 0; first = -1; last = -1; stalls = 0;
      got_done = 1'b0; did_load = 1'b0; aborted = 1'b0; last_out = '0;
      for (int cyc = 1; cyc < 80 && !got_done && !aborted; cyc++) begin
         @(negedge clk);
         bus.stall = 1'b0;
         bus.load  = 1'b0;
         if (bus.a_valid) begin
            if (first < 0) first = cyc;
            last = cyc;
            beats++;
            if (sb.size() > 0) chk($sformatf("beat%0d", beats - 1), bus.a_out, sb.pop_front());
            else chk("sb_underflow", W'(1), W'(0));
            last_out = bus.a_out;
         end else if (bus.done) begin
            got_done = 1'b1;
            chk("done_flags", flags(), W'({3'b011, exp_err}));
            chk("done_aout", bus.a_out, '0);
            chk("beat_count", W'(beats), W'(NB));
            chk("span", W'(last - first + 1), W'(NB + stall_len));
            chk("first_latency", W'(first), W'(1));
            chk("done_gap", W'(cyc - last), W'(1));
         end else begin
            chk("stall_hold", bus.a_out, last_out);
         end
         if (abort_at >= 0 && beats == abort_at + 1) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_flags", flags(), '0);
            chk("abort_aout", bus.a_out, '0);
            sb.delete();
            clear_model();
            aborted = 1'b1;
         end else begin
            if (beats == stall_after + 1 && stalls < stall_len) begin
               bus.stall = 1'b1;
               stalls++;
            end
            if (load_mid && beats == 3 && !did_load) begin
               bus.load     = 1'b1;
               bus.load_row = 3'd2;
               bus.row_in   = {W{1'b1}};
               did_load     = 1'b1;
            end
         end
      end
      if (!aborted) begin
         if (!got_done) chk("done_timeout", W'(0), W'(1));
         @(negedge clk);
         chk("post_flags", flags(), W'({3'b000, exp_err}));
         chk("sb_empty", W'(sb.size()), W'(0));
      end
   endtask

   initial begin
      logic [W-1:0] row;
      bus.load = 1'b0; bus.load_row = '0; bus.row_in = '0;
      bus.start = 1'b0; bus.stall = 1'b0;
      clear_model();

      // Scenario 1: reset state, then a stream of an all-zero tile.
      #3;
      chk("reset_flags", flags(), '0);
      chk("reset_aout", bus.a_out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_stream(-1, 0, 1'b0, -1, 1'b0);

      // Scenario 2: tile A[r][c] = 8r+c+1, unstalled.
      for (int r = 0; r < D; r++) begin
         for (int c = 0; c < D; c++) row[c*B +: B] = 8'(8 * r + c + 1);
         do_load(r, row);
      end
      run_stream(-1, 0, 1'b0, -1, 1'b0);

      // Scenario 3: three-cycle stall after beat 4.
      run_stream(4, 3, 1'b0, -1, 1'b0);

      // Scenario 4: write during stream flags an error and leaves the tile alone.
      run_stream(-1, 0, 1'b1, -1, 1'b1);
      run_stream(-1, 0, 1'b0, -1, 1'b0);

      // Scenario 5: load and start together -> write only.
      for (int c = 0; c < D; c++) row[c*B +: B] = 8'(8'hA0 + c);
      bus.start = 1'b1;
      do_load(5, row);
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ld_start_idle%0d", k), flags(), '0);
         @(negedge clk);
      end
      run_stream(-1, 0, 1'b0, -1, 1'b0);

      // Scenario 6: reset at beat 9, then the cleared tile streams zeros.
      run_stream(-1, 0, 1'b0, 9, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("post_abort_quiet%0d", k), flags(), '0);
      end
      run_stream(-1, 0, 1'b0, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
